// File: rtl/fifo_port_ram.sv
// fifo_port_ram: single-clock first-word-fall-through FIFO with internal storage.
// Responder side of the FIFO_WRITE / FIFO_READ port pair.
// Optional feature macro: FIFO_PORT_RAM_FLAGS_EN adds sticky fifo_overflow /
// fifo_underflow outputs; the data path is identical with or without it.
module fifo_port_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    output logic                  fifo_write_full,
    input  logic [DATA_WIDTH-1:0] fifo_write_data,
    input  logic                  fifo_write_wren,
    output logic                  fifo_read_empty,
    output logic [DATA_WIDTH-1:0] fifo_read_data,
    input  logic                  fifo_read_rden,
`ifdef FIFO_PORT_RAM_FLAGS_EN
    output logic                  fifo_overflow,
    output logic                  fifo_underflow,
`endif
    output logic [ADDR_WIDTH:0]   data_count
);

    localparam int unsigned         DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  push, pop;

    // Qualify requests against the registered flags; compute next pointers, count and flags
    always_comb begin
        push     = fifo_write_wren & ~full_q;
        pop      = fifo_read_rden & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
        // Flags come from the next count so they are valid right after the edge
        full_d  = (count_d == FULL_COUNT);
        empty_d = (count_d == '0);
    end

    // Pointer, count and flag registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage write; contents are deliberately not reset, stale words are masked by empty
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= fifo_write_data;
        end
    end

    // Output drive: head word falls through combinationally, forced to zero while empty
    always_comb begin
        fifo_write_full = full_q;
        fifo_read_empty = empty_q;
        data_count      = count_q;
        fifo_read_data  = empty_q ? '0 : mem_q[rd_ptr_q];
    end

`ifdef FIFO_PORT_RAM_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: set by any request that hits a blocking flag, clear only on reset
    always_comb begin
        overflow_d  = overflow_q | (fifo_write_wren & full_q);
        underflow_d = underflow_q | (fifo_read_rden & empty_q);
    end

    // Error flag registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Error flag outputs
    always_comb begin
        fifo_overflow  = overflow_q;
        fifo_underflow = underflow_q;
    end
`endif

endmodule

// File: tb/tb_fifo_port_ram.sv
// tb_fifo_port_ram: directed, table-driven bench for fifo_port_ram (depth 8, 8-bit words).
// Flag checks are compiled in only when FIFO_PORT_RAM_FLAGS_EN is defined.
module tb_fifo_port_ram;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic          aclk;
    logic          aresetn;
    logic          wr_full;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          rd_empty;
    logic [DW-1:0] rd_data;
    logic          rd_en;
    logic [AW:0]   count;
`ifdef FIFO_PORT_RAM_FLAGS_EN
    logic          ovf;
    logic          unf;
`endif

    int tests;
    int fails;

    fifo_port_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .fifo_write_full (wr_full),
        .fifo_write_data (wr_data),
        .fifo_write_wren (wr_en),
        .fifo_read_empty (rd_empty),
        .fifo_read_data  (rd_data),
        .fifo_read_rden  (rd_en),
`ifdef FIFO_PORT_RAM_FLAGS_EN
        .fifo_overflow   (ovf),
        .fifo_underflow  (unf),
`endif
        .data_count      (count)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct {
        logic          wren;
        logic [DW-1:0] wdata;
        logic          rden;
        logic          exp_empty;
        logic          exp_full;
        logic [AW:0]   exp_count;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic e, input logic f,
                             input logic [AW:0] c, input logic [DW-1:0] d);
        chk({name, ".empty"}, 32'(rd_empty), 32'(e));
        chk({name, ".full"}, 32'(wr_full), 32'(f));
        chk({name, ".count"}, 32'(count), 32'(c));
        chk({name, ".data"}, 32'(rd_data), 32'(d));
    endtask

    // Drive one cycle of requests, sample 2 time units after the rising edge
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge aclk);
        #2;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        aresetn = 1'b0;

        //              wren  wdata  rden  empty full count  data
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 4'd1, 8'h11};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 4'd2, 8'h11};
        vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 4'd3, 8'h11};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 4'd4, 8'h11};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd3, 8'h22};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2, 8'h33};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd1, 8'h44};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00};  // pop on empty
        vecs[9]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 4'd1, 8'h5A};  // wr+rd while empty
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00};

        // Reset state
        #12;
        chk_state("reset", 1'b1, 1'b0, 4'd0, 8'h00);
`ifdef FIFO_PORT_RAM_FLAGS_EN
        chk("reset.ovf", 32'(ovf), 32'd0);
        chk("reset.unf", 32'(unf), 32'd0);
`endif
        @(negedge aclk);
        aresetn = 1'b1;

        // Table-driven basic sequence
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].wren, vecs[i].wdata, vecs[i].rden);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_empty, vecs[i].exp_full,
                      vecs[i].exp_count, vecs[i].exp_data);
        end
`ifdef FIFO_PORT_RAM_FLAGS_EN
        chk("underflow_set", 32'(unf), 32'd1);
        chk("overflow_clear", 32'(ovf), 32'd0);
`endif

        // Fill to full, drop a ninth push, drain the original eight
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(8'h80 + i), 1'b0);
        end
        chk_state("fill8", 1'b0, 1'b1, 4'd8, 8'h80);
        cycle(1'b1, 8'hFF, 1'b0);
        chk_state("push_full_dropped", 1'b0, 1'b1, 4'd8, 8'h80);
`ifdef FIFO_PORT_RAM_FLAGS_EN
        chk("overflow_set", 32'(ovf), 32'd1);
`endif
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain8_%0d", i), 32'(rd_data), 32'(8'h80 + i));
            cycle(1'b0, 8'h00, 1'b1);
        end
        chk_state("drained", 1'b1, 1'b0, 4'd0, 8'h00);

        // Simultaneous wr+rd while full: pop happens, push dropped
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(8'h90 + i), 1'b0);
        end
        cycle(1'b1, 8'hEE, 1'b1);
        chk_state("wr_rd_full", 1'b0, 1'b0, 4'd7, 8'h91);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("drain7_%0d", i), 32'(rd_data), 32'(8'h90 + i));
            cycle(1'b0, 8'h00, 1'b1);
        end
        chk_state("drained7", 1'b1, 1'b0, 4'd0, 8'h00);

        // Sustained push+pop at occupancy 3; pointers wrap several times
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("stream_head%0d", i), 32'(rd_data), 32'(8'hC0 + i));
            cycle(1'b1, 8'(8'hC3 + i), 1'b1);
            chk($sformatf("stream_count%0d", i), 32'(count), 32'd3);
        end
        for (int i = 20; i < 23; i++) begin
            chk($sformatf("stream_tail%0d", i), 32'(rd_data), 32'(8'hC0 + i));
            cycle(1'b0, 8'h00, 1'b1);
        end
        chk_state("stream_done", 1'b1, 1'b0, 4'd0, 8'h00);
`ifdef FIFO_PORT_RAM_FLAGS_EN
        chk("underflow_sticky", 32'(unf), 32'd1);
`endif

        // Asynchronous reset mid-stream with five words held
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'(8'h60 + i), 1'b0);
        end
        chk_state("pre_reset", 1'b0, 1'b0, 4'd5, 8'h60);
        #1;
        aresetn = 1'b0;
        #1;
        chk_state("async_reset", 1'b1, 1'b0, 4'd0, 8'h00);
`ifdef FIFO_PORT_RAM_FLAGS_EN
        chk("async_reset.ovf", 32'(ovf), 32'd0);
        chk("async_reset.unf", 32'(unf), 32'd0);
`endif
        @(posedge aclk);
        #2;
        chk_state("reset_held", 1'b1, 1'b0, 4'd0, 8'h00);
        aresetn = 1'b1;
        cycle(1'b1, 8'hA5, 1'b0);
        chk_state("post_reset_push", 1'b0, 1'b0, 4'd1, 8'hA5);
        cycle(1'b0, 8'h00, 1'b1);
        chk_state("post_reset_pop", 1'b1, 1'b0, 4'd0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
